// File: rtl/rv_pkg.sv
// rtl/rv_pkg.sv - shared RV32I format codes, field widths and encoding helpers
package rv_pkg;

  localparam int FMT_W   = 3;
  localparam int OPC_W   = 7;
  localparam int REG_W   = 5;
  localparam int F3_W    = 3;
  localparam int F7_W    = 7;
  localparam int INSTR_W = 32;

  localparam logic [INSTR_W-1:0] NOP = 32'h00000013;

  typedef enum logic [FMT_W-1:0] {
    FMT_I  = 3'd0,
    FMT_U  = 3'd1,
    FMT_S  = 3'd2,
    FMT_R  = 3'd3,
    FMT_SB = 3'd4,
    FMT_UJ = 3'd5
  } fmt_e;

  typedef struct packed {
    logic               err;
    logic [INSTR_W-1:0] instr;
  } enc_word_t;

  // True when imm[31:msb] are all copies of imm[msb], i.e. the value fits
  // in a signed field whose top bit is msb.
  function automatic logic sext_ok(input logic [31:0] imm, input int unsigned msb);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < 32; i++) begin
      if (i > msb && imm[i] != imm[msb]) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/instr_pack.sv
// rtl/instr_pack.sv - combinational field bundle to {err, instr} packer
import rv_pkg::*;

module instr_pack (
  input  logic [FMT_W-1:0]   fmt,
  input  logic [OPC_W-1:0]   opcode,
  input  logic [REG_W-1:0]   rd,
  input  logic [REG_W-1:0]   rs1,
  input  logic [REG_W-1:0]   rs2,
  input  logic [F3_W-1:0]    funct3,
  input  logic [F7_W-1:0]    funct7,
  input  logic [31:0]        imm,
  output enc_word_t          word
);

  logic [INSTR_W-1:0] raw;
  logic               legal;

  // Pack fields by format and decide legality; illegal words collapse to NOP.
  always_comb begin
    raw   = '0;
    legal = 1'b0;
    case (fmt)
      FMT_R: begin
        raw   = {funct7, rs2, rs1, funct3, rd, opcode};
        legal = 1'b1;
      end
      FMT_I: begin
        raw   = {imm[11:0], rs1, funct3, rd, opcode};
        legal = sext_ok(imm, 11);
      end
      FMT_S: begin
        raw   = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
        legal = sext_ok(imm, 11);
      end
      FMT_SB: begin
        raw   = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
        legal = sext_ok(imm, 12) && !imm[0];
      end
      FMT_U: begin
        raw   = {imm[31:12], rd, opcode};
        legal = (imm[11:0] == 12'd0);
      end
      FMT_UJ: begin
        raw   = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
        legal = sext_ok(imm, 20) && !imm[0];
      end
      default: begin
        raw   = '0;
        legal = 1'b0;
      end
    endcase
    if (opcode[1:0] != 2'b11) legal = 1'b0;
    word.err   = !legal;
    word.instr = legal ? raw : NOP;
  end

endmodule

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - pipelined RV32I encoder with 2-entry output buffer
import rv_pkg::*;

module instr_encoder #(
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [FMT_W-1:0]   in_fmt,
  input  logic [OPC_W-1:0]   in_opcode,
  input  logic [REG_W-1:0]   in_rd,
  input  logic [REG_W-1:0]   in_rs1,
  input  logic [REG_W-1:0]   in_rs2,
  input  logic [F3_W-1:0]    in_funct3,
  input  logic [F7_W-1:0]    in_funct7,
  input  logic [31:0]        in_imm,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic               out_err,
  output logic [CNT_W-1:0]   accept_cnt
);

  enc_word_t  packed_word;
  enc_word_t  mem [2];
  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] count;
  logic       push;
  logic       pop;

  instr_pack u_pack (
    .fmt    (in_fmt),
    .opcode (in_opcode),
    .rd     (in_rd),
    .rs1    (in_rs1),
    .rs2    (in_rs2),
    .funct3 (in_funct3),
    .funct7 (in_funct7),
    .imm    (in_imm),
    .word   (packed_word)
  );

  // Ready depends only on stored occupancy so a full buffer never chains
  // out_ready into in_ready.
  assign in_ready  = (count < 2'd2);
  assign out_valid = (count != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign out_instr = mem[rd_ptr].instr;
  assign out_err   = mem[rd_ptr].err;

  // Buffer storage, pointers, occupancy and saturating accept counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0]     <= '0;
      mem[1]     <= '0;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      count      <= 2'd0;
      accept_cnt <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= packed_word;
        wr_ptr      <= !wr_ptr;
        if (accept_cnt != {CNT_W{1'b1}}) accept_cnt <= accept_cnt + 1'b1;
      end
      if (pop) rd_ptr <= !rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// tb/tb_instr_encoder.sv - randomized self-checking bench for instr_encoder
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_fmt;
  logic [6:0]  in_opcode;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_err;
  logic [15:0] accept_cnt;

  logic        s_in_ready, s_out_valid, s_out_err;
  logic [31:0] s_out_instr;
  logic [1:0]  s_acc;

  typedef struct {
    logic        err;
    logic [31:0] instr;
  } word_t;

  word_t q[$];
  int    n_push = 0;
  int    tests  = 0;
  int    fails  = 0;

  always #5 clk = !clk;

  instr_encoder #(.CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_fmt(in_fmt), .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1),
    .in_rs2(in_rs2), .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_err(out_err), .accept_cnt(accept_cnt)
  );

  instr_encoder #(.CNT_W(2)) dut_small (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_fmt(in_fmt), .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1),
    .in_rs2(in_rs2), .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_instr(s_out_instr),
    .out_err(s_out_err), .accept_cnt(s_acc)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference encoder: numeric range checks and shift/mask field placement.
  function automatic word_t ref_word(input logic [2:0] f, input logic [6:0] op,
                                     input logic [4:0] rd, input logic [4:0] rs1,
                                     input logic [4:0] rs2, input logic [2:0] f3,
                                     input logic [6:0] f7, input logic [31:0] imm);
    word_t       r;
    int          s;
    bit          ok;
    logic [31:0] w;
    s  = $signed(imm);
    ok = 0;
    w  = 0;
    case (f)
      3'd0: begin
        ok = (s >= -2048) && (s <= 2047);
        w  = ((imm & 32'hFFF) << 20) | (32'(rs1) << 15) | (32'(f3) << 12) | (32'(rd) << 7) | 32'(op);
      end
      3'd1: begin
        ok = (imm % 4096) == 0;
        w  = (imm & 32'hFFFFF000) | (32'(rd) << 7) | 32'(op);
      end
      3'd2: begin
        ok = (s >= -2048) && (s <= 2047);
        w  = (((imm >> 5) & 32'h7F) << 25) | (32'(rs2) << 20) | (32'(rs1) << 15) |
             (32'(f3) << 12) | ((imm & 32'h1F) << 7) | 32'(op);
      end
      3'd3: begin
        ok = 1;
        w  = (32'(f7) << 25) | (32'(rs2) << 20) | (32'(rs1) << 15) | (32'(f3) << 12) |
             (32'(rd) << 7) | 32'(op);
      end
      3'd4: begin
        ok = (s >= -4096) && (s <= 4095) && (imm % 2 == 0);
        w  = (((imm >> 12) & 1) << 31) | (((imm >> 5) & 32'h3F) << 25) | (32'(rs2) << 20) |
             (32'(rs1) << 15) | (32'(f3) << 12) | (((imm >> 1) & 32'hF) << 8) |
             (((imm >> 11) & 1) << 7) | 32'(op);
      end
      3'd5: begin
        ok = (s >= -(1 << 20)) && (s <= (1 << 20) - 1) && (imm % 2 == 0);
        w  = (((imm >> 20) & 1) << 31) | (((imm >> 1) & 32'h3FF) << 21) |
             (((imm >> 11) & 1) << 20) | (((imm >> 12) & 32'hFF) << 12) |
             (32'(rd) << 7) | 32'(op);
      end
      default: ok = 0;
    endcase
    if (op % 4 != 3) ok = 0;
    r.err   = !ok;
    r.instr = ok ? w : 32'h00000013;
    return r;
  endfunction

  // Per-cycle compare against the queue model, then advance the model by the
  // transfers the coming rising edge will perform.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_out_instr", out_instr, 0);
      chk("rst_out_err", 32'(out_err), 0);
      chk("rst_accept_cnt", 32'(accept_cnt), 0);
      q.delete();
      n_push = 0;
    end else begin
      bit    do_push, do_pop;
      word_t w;
      chk("in_ready", 32'(in_ready), 32'(q.size() < 2));
      chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
      if (q.size() != 0) begin
        chk("out_instr", out_instr, q[0].instr);
        chk("out_err", 32'(out_err), 32'(q[0].err));
      end
      chk("accept_cnt", 32'(accept_cnt), (n_push > 65535) ? 65535 : n_push);
      chk("accept_cnt_sat", 32'(s_acc), (n_push > 3) ? 3 : n_push);
      do_push = in_valid && (q.size() < 2);
      do_pop  = (q.size() != 0) && out_ready;
      if (do_pop) void'(q.pop_front());
      if (do_push) begin
        w = ref_word(in_fmt, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm);
        q.push_back(w);
        n_push++;
      end
    end
  end

  task automatic drive(input logic [2:0] f, input logic [6:0] op, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [31:0] imm);
    in_fmt = f; in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_funct3 = f3; in_funct7 = f7; in_imm = imm;
  endtask

  task automatic directed(input string name, input logic [2:0] f, input logic [6:0] op,
                          input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] imm,
                          input logic [31:0] exp_instr, input logic exp_err);
    @(posedge clk); #1;
    drive(f, op, rd, rs1, rs2, f3, f7, imm);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk({name, "_valid"}, 32'(out_valid), 1);
    chk({name, "_instr"}, out_instr, exp_instr);
    chk({name, "_err"}, 32'(out_err), 32'(exp_err));
  endtask

  initial begin
    word_t m;
    int    guard;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);

    m = ref_word(3'd0, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
    chk("model_I", m.instr, 32'h00500093);
    m = ref_word(3'd4, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFFFFFC);
    chk("model_SB", m.instr, 32'hFE208EE3);
    m = ref_word(3'd4, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd3);
    chk("model_SB_odd_err", 32'(m.err), 1);

    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    directed("I",     3'd0, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5,          32'h00500093, 1'b0);
    directed("R",     3'd3, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0,          32'h002081B3, 1'b0);
    directed("S",     3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8,          32'h0020A423, 1'b0);
    directed("SB",    3'd4, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFFFFFC,   32'hFE208EE3, 1'b0);
    directed("U",     3'd1, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000,   32'h123452B7, 1'b0);
    directed("E_fmt6",3'd6, 7'h13, 5'd1, 5'd1, 5'd1, 3'd0, 7'd0, 32'd0,          32'h00000013, 1'b1);
    directed("E_sb3", 3'd4, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd3,          32'h00000013, 1'b1);
    directed("E_i800",3'd0, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h800,        32'h00000013, 1'b1);
    chk("accept_after_directed", 32'(accept_cnt), 8);
    chk("accept_small_saturated", 32'(s_acc), 3);

    // Backpressure: three back-to-back offers into a stalled consumer.
    @(posedge clk); #1;
    out_ready = 1'b0;
    drive(3'd0, 7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1); in_valid = 1'b1;
    @(posedge clk); #1;
    drive(3'd0, 7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2);
    @(posedge clk); #1;
    drive(3'd0, 7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3);
    @(negedge clk);
    chk("bp_full_ready", 32'(in_ready), 0);
    chk("bp_head", out_instr, 32'h00100113);
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_still_full", 32'(in_ready), 0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (!in_ready && guard < 10);
    chk("bp_third_accept_timeout", 32'(in_ready), 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("bp_third_word", out_instr, 32'h00300113);
    repeat (3) @(posedge clk);

    // Reset with two words buffered.
    #1;
    out_ready = 1'b0;
    drive(3'd0, 7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1); in_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 0);
    chk("midrst_accept_cnt", 32'(accept_cnt), 0);
    chk("midrst_small_cnt", 32'(s_acc), 0);
    chk("midrst_in_ready", 32'(in_ready), 1);
    @(posedge clk); #2;
    rst_n = 1'b1;

    // Randomized traffic with random backpressure.
    for (int c = 0; c < 3000; c++) begin
      logic [31:0] imm;
      logic [6:0]  op;
      @(posedge clk); #1;
      case ($urandom_range(0, 3))
        0:       imm = 32'($signed($urandom_range(0, 4095)) - 2048);
        1:       imm = $urandom;
        2:       imm = $urandom & 32'hFFFFF000;
        default: imm = 32'(int'($urandom_range(0, (1 << 21) - 1)) - (1 << 20)) & ~32'($urandom_range(0, 1));
      endcase
      op = ($urandom_range(0, 7) == 0) ? 7'($urandom) : (7'($urandom) | 7'h03);
      drive(3'($urandom_range(0, 7)), op, 5'($urandom), 5'($urandom), 5'($urandom),
            3'($urandom), 7'($urandom), imm);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
